// File: rtl/pea_cfdf_enable_invoke.sv
// CFDF enable/invoke parent controller for the polynomial evaluation actor's FSM2.
// Optional firing watchdog: define PEA_FIRING_TIMEOUT_EN.
module pea_cfdf_enable_invoke #(
   parameter int unsigned word_size      = 16,
   parameter int unsigned buffer_size    = 1024,
   parameter int unsigned timeout_cycles = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 invoke,
   input  logic [word_size-1:0] pop_in_fifo_data,
   input  logic [word_size-1:0] pop_in_fifo_command,
   input  logic [word_size-1:0] pop_out_fifo_result,
   input  logic [7:0]           instr,
   input  logic [4:0]           arg2,
   input  logic                 done_fsm2,
   output logic                 start_fsm2,
   output logic [1:0]           next_instr,
   output logic                 enabled,
   output logic                 done_invoke,
   output logic                 fired,
   output logic                 err
);

   localparam int unsigned XW = word_size + 1;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_START, S_WAIT, S_UPDATE} state_t;
   typedef enum logic {SETUP_INSTR = 1'b0, INSTR = 1'b1} mode_t;

   state_t state, state_nxt;
   mode_t  mode, mode_nxt;
   logic   err_nxt, enabled_nxt, start_nxt, done_nxt, fired_nxt;
   logic   en, bad, expired;

   logic [XW-1:0] data_x, cmd_x, res_x, arg_x, arg_p1, buf_x, free;

   assign data_x = {1'b0, pop_in_fifo_data};
   assign cmd_x  = {1'b0, pop_in_fifo_command};
   assign res_x  = {1'b0, pop_out_fifo_result};
   assign arg_x  = {{(XW-5){1'b0}}, arg2};
   assign arg_p1 = arg_x + XW'(1);
   assign buf_x  = XW'(buffer_size);
   // An overfull result FIFO reports zero free space rather than wrapping.
   assign free   = (res_x > buf_x) ? '0 : buf_x - res_x;

   always_comb begin
      en  = 1'b0;
      bad = 1'b0;
      if (mode == SETUP_INSTR) begin
         en = cmd_x >= XW'(1);
      end else begin
         case (instr)
            8'd0:    en = data_x >= arg_p1;
            8'd1:    en = (data_x >= XW'(1)) && (free >= XW'(1));
            8'd2:    en = (data_x >= arg_x) && (free >= arg_x) && (arg2 != 5'd0);
            8'd3:    en = 1'b1;
            default: bad = 1'b1;
         endcase
      end
   end

`ifdef PEA_FIRING_TIMEOUT_EN
   localparam int unsigned CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= '0;
      else if (state == S_START) cnt <= '0;
      else if (state == S_WAIT)  cnt <= cnt + CW'(1);
   end

   assign expired = (cnt == CW'(timeout_cycles - 1));
`else
   // Without the watchdog the timeout parameter only shapes the interface.
   logic unused_timeout;
   assign unused_timeout = ^timeout_cycles;
   assign expired        = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode;
      err_nxt     = err;
      enabled_nxt = enabled;
      start_nxt   = 1'b0;
      done_nxt    = 1'b0;
      fired_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (invoke) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            enabled_nxt = en;
            if (bad) begin
               err_nxt  = 1'b1;
               mode_nxt = SETUP_INSTR;
            end
            if (en) begin
               state_nxt = S_START;
               start_nxt = 1'b1;
            end else begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         S_START: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Completion takes priority over a coincident watchdog expiry.
            if (done_fsm2) begin
               state_nxt = S_UPDATE;
               done_nxt  = 1'b1;
               fired_nxt = 1'b1;
               mode_nxt  = (mode == SETUP_INSTR) ? INSTR : SETUP_INSTR;
            end else if (expired) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
               err_nxt   = 1'b1;
               mode_nxt  = SETUP_INSTR;
            end
         end
         S_UPDATE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Pulse outputs are registered so they are high during S_START / S_UPDATE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         mode        <= SETUP_INSTR;
         err         <= 1'b0;
         enabled     <= 1'b0;
         start_fsm2  <= 1'b0;
         done_invoke <= 1'b0;
         fired       <= 1'b0;
      end else begin
         state       <= state_nxt;
         mode        <= mode_nxt;
         err         <= err_nxt;
         enabled     <= enabled_nxt;
         start_fsm2  <= start_nxt;
         done_invoke <= done_nxt;
         fired       <= fired_nxt;
      end
   end

   assign next_instr = {1'b0, mode};

endmodule

// File: tb/tb_pea_cfdf_enable_invoke.sv
// Scoreboard bench for pea_cfdf_enable_invoke: a rule-level enable model predicts
// each invocation outcome; a monitor checks start_fsm2 and done_invoke as they occur.
module tb_pea_cfdf_enable_invoke;

   localparam int unsigned W   = 16;
   localparam int          BUF = 1024;
   localparam int          TMO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         invoke;
   logic [W-1:0] pop_in_fifo_data, pop_in_fifo_command, pop_out_fifo_result;
   logic [7:0]   instr;
   logic [4:0]   arg2;
   logic         done_fsm2;
   logic         start_fsm2;
   logic [1:0]   next_instr;
   logic         enabled, done_invoke, fired, err;

   pea_cfdf_enable_invoke #(
      .word_size(W),
      .buffer_size(BUF),
      .timeout_cycles(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .invoke(invoke),
      .pop_in_fifo_data(pop_in_fifo_data),
      .pop_in_fifo_command(pop_in_fifo_command),
      .pop_out_fifo_result(pop_out_fifo_result),
      .instr(instr),
      .arg2(arg2),
      .done_fsm2(done_fsm2),
      .start_fsm2(start_fsm2),
      .next_instr(next_instr),
      .enabled(enabled),
      .done_invoke(done_invoke),
      .fired(fired),
      .err(err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          fired;
      bit          enabled;
      bit          err;
      bit          mode;
      int unsigned issue;
      int unsigned lat;
   } exp_t;

   exp_t exp_q[$];
   bit   start_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   m_mode   = 1'b0;
   bit   m_err    = 1'b0;
   int   fsm2_delay = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event present, none required (t=%0t)", name, $time);
   endtask

   // Enable rules for one invocation, written directly from the actor's firing rules.
   function automatic bit model_en(input bit mode, input int cmd, input int data, input int res,
                                   input int ins, input int a2, output bit bad);
      int free;
      free = BUF - res;
      bad  = 1'b0;
      if (!mode) return cmd >= 1;
      case (ins)
         0:       return data >= a2 + 1;
         1:       return (data >= 1) && (free >= 1);
         2:       return (data >= a2) && (free >= a2) && (a2 != 0);
         3:       return 1'b1;
         default: begin bad = 1'b1; return 1'b0; end
      endcase
   endfunction

   // Monitor: compares every DUT-presented event against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      bit   m;
      if (rst === 1'b1) begin
         if (start_fsm2) begin
            if (start_q.size() == 0) fail_now("unexpected_start_fsm2");
            else begin
               m = start_q.pop_front();
               check("next_instr_at_start", 32'(next_instr), 32'({1'b0, m}));
            end
         end
         if (done_invoke) begin
            if (exp_q.size() == 0) fail_now("unexpected_done_invoke");
            else begin
               e = exp_q.pop_front();
               check("fired", 32'(fired), 32'(e.fired));
               check("enabled", 32'(enabled), 32'(e.enabled));
               check("err", 32'(err), 32'(e.err));
               check("next_instr_after", 32'(next_instr), 32'({1'b0, e.mode}));
               check("latency", cyc - e.issue, e.lat);
            end
         end
      end
   end

   // FSM2 stand-in: answers each start pulse after fsm2_delay cycles (0 = never).
   initial begin
      done_fsm2 = 1'b0;
      forever begin
         @(negedge clk);
         if (start_fsm2 && fsm2_delay > 0) begin
            repeat (fsm2_delay) @(posedge clk);
            #1 done_fsm2 = 1'b1;
            @(posedge clk);
            #1 done_fsm2 = 1'b0;
         end
      end
   end

   task automatic do_invoke(input int cmd, input int data, input int res,
                            input int ins, input int a2, input int d);
      exp_t e;
      bit   bad, en, seen;
      en        = model_en(m_mode, cmd, data, res, ins, a2, bad);
      e.enabled = en;
      e.issue   = cyc;
      if (en) begin
         start_q.push_back(m_mode);
         if (d > 0) begin
            e.fired = 1'b1;
            m_mode  = !m_mode;
            e.lat   = 3 + d;
         end else begin
            e.fired = 1'b0;
            m_err   = 1'b1;
            m_mode  = 1'b0;
            e.lat   = 3 + TMO;
         end
      end else begin
         e.fired = 1'b0;
         if (bad) begin
            m_err  = 1'b1;
            m_mode = 1'b0;
         end
         e.lat = 2;
      end
      e.err  = m_err;
      e.mode = m_mode;
      exp_q.push_back(e);

      pop_in_fifo_command = W'(cmd);
      pop_in_fifo_data    = W'(data);
      pop_out_fifo_result = W'(res);
      instr               = 8'(ins);
      arg2                = 5'(a2);
      fsm2_delay          = d;
      invoke              = 1'b1;
      @(posedge clk);
      #1 invoke = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done_invoke) seen = 1'b1;
      end
      if (!seen) begin
         check("done_invoke_timeout", 32'd0, 32'd1);
         exp_q.delete();
         start_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_fsm2"}, 32'(start_fsm2), 32'd0);
      check({tag, "_enabled"}, 32'(enabled), 32'd0);
      check({tag, "_done_invoke"}, 32'(done_invoke), 32'd0);
      check({tag, "_fired"}, 32'(fired), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_next_instr"}, 32'(next_instr), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, dt, rs, ins, r;
      rst = 1'b0;
      invoke = 1'b0;
      pop_in_fifo_data = '0;
      pop_in_fifo_command = '0;
      pop_out_fifo_result = '0;
      instr = '0;
      arg2 = '0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed boundary cases.
      do_invoke(0, 0, 0, 0, 0, 1);       // no command token: no firing
      do_invoke(3, 0, 0, 0, 0, 5);       // setup fires, mode -> INSTR
      do_invoke(0, 4, 0, 0, 4, 1);       // STP needs N+1 data
      do_invoke(0, 5, 0, 0, 4, 2);       // STP fires, mode -> SETUP
      do_invoke(1, 0, 0, 0, 0, 3);
      do_invoke(0, 3, 1022, 2, 3, 1);    // EVB: free 2 < b 3
      do_invoke(0, 3, 1021, 2, 3, 2);    // EVB fires
      do_invoke(1, 0, 0, 0, 0, 1);
      do_invoke(0, 9, 1024, 1, 0, 1);    // EVP: no free space
      do_invoke(0, 1, 1023, 1, 0, 1);    // EVP fires
      do_invoke(1, 0, 0, 0, 0, 1);
      do_invoke(0, 30, 0, 2, 0, 1);      // EVB with b=0 never fires
      do_invoke(0, 0, 0, 7, 0, 1);       // illegal instr: err, back to setup
      do_invoke(0, 0, 0, 7, 0, 1);
      do_invoke(2, 0, 0, 0, 0, 4);       // err remains sticky

      // Reset while waiting on FSM2.
      pop_in_fifo_command = W'(1);
      instr = 8'd3;
      fsm2_delay = 0;
      start_q.push_back(m_mode);
      invoke = 1'b1;
      @(posedge clk);
      #1 invoke = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      start_q.delete();
      m_mode = 1'b0;
      m_err = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Randomized invocations biased toward enable thresholds.
      for (int n = 0; n < 150; n++) begin
         a   = int'($urandom_range(0, 31));
         r   = int'($urandom_range(0, 19));
         ins = (r == 19) ? int'($urandom_range(4, 255)) : r % 4;
         dt  = ($urandom_range(0, 1) == 1) ? a + int'($urandom_range(0, 2)) - 1
                                           : int'($urandom_range(0, 40));
         if (dt < 0) dt = 0;
         rs  = ($urandom_range(0, 1) == 1) ? BUF - a + int'($urandom_range(0, 2)) - 1
                                           : int'($urandom_range(0, BUF));
         if (rs < 0) rs = 0;
         if (rs > BUF) rs = BUF;
         do_invoke(int'($urandom_range(0, 2)), dt, rs, ins, a, int'($urandom_range(1, 6)));
      end

`ifdef PEA_FIRING_TIMEOUT_EN
      do_invoke(1, 0, 0, 3, 0, 0);       // FSM2 never answers
      do_invoke(0, 0, 0, 0, 0, 1);
`endif

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("start_queue_drained", 32'(start_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
